// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file.
// Picks the writeback value (load data or ALU result), commits it to the
// register file, serves two ID-stage read ports with write-through bypass,
// exposes a raw debug read port and counts committed writes.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_m2r,
    input  logic              wb_regwr,
    input  logic [DATA_W-1:0] wb_memdata,
    input  logic [DATA_W-1:0] wb_aluout,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 is only ever cleared by reset and never written, so it is a
    // constant zero that synthesis folds away; reads of $0 are forced to 0.
    logic [DATA_W-1:0] regs [DEPTH];

    // Writeback value selection; independent of reset.
    always_comb begin
        wb_data = wb_m2r ? wb_memdata : wb_aluout;
    end

    // A write only takes effect for a non-zero destination outside reset.
    always_comb begin
        wb_en = wb_regwr & (wb_rd != '0) & ~rst;
    end

    // Register array update; reset clears every entry immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wb_en && (wb_rd == ADDR_W'(i))) begin
                    regs[i] <= wb_data;
                end
            end
        end
    end

    // Read port A with same-cycle bypass of the pending writeback.
    always_comb begin
        rs_data = '0;
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wb_en && (rs_addr == wb_rd)) begin
            rs_data = wb_data;
        end else begin
            rs_data = regs[rs_addr];
        end
    end

    // Read port B with same-cycle bypass of the pending writeback.
    always_comb begin
        rt_data = '0;
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wb_en && (rt_addr == wb_rd)) begin
            rt_data = wb_data;
        end else begin
            rt_data = regs[rt_addr];
        end
    end

    // Debug port shows the raw array contents so commit timing is visible.
    always_comb begin
        dbg_data = '0;
        if (dbg_addr != '0) begin
            dbg_data = regs[dbg_addr];
        end
    end

    // Count of committed writes; wraps naturally at the counter width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wb_en) begin
            wr_count <= wr_count + CNT_W'(1);
        end
    end

endmodule
